mc_control_unit: RTL and testbench

Multicycle control unit for the ARM-subset processor: a Moore state machine plus condition-flag register that sequences the datapath through fetch, decode, execute, memory and writeback. It sits directly upstream of the datapath. It consumes `Instr` and `ALUFlags` and drives every datapath control input, including the high-half register write for UMULL/SMULL.

---
 rtl/ctrl_pkg.sv | 28 ++
 rtl/mc_control_unit_cond_check.sv | 32 +++
 rtl/mc_control_unit.sv | 123 ++++++++++++
 tb/tb_mc_control_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state enum, datapath select codes, op/cmd/cond constants and cmd decode helpers for mc_control_unit
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_MULEX, S_MULWB
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100, ALU_MUL = 3'b101, ALU_UMULL = 3'b110, ALU_SMULL = 3'b111;
  localparam logic [1:0] IMM_DP = 2'b00, IMM_MEM = 2'b01, IMM_BR = 2'b10;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10;
  localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_UND = 2'b11;
  localparam logic [3:0] CMD_AND = 4'b0000, CMD_EOR = 4'b0001, CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100, CMD_CMP = 4'b1010, CMD_ORR = 4'b1100;
  localparam logic [3:0] COND_EQ = 4'd0, COND_NE = 4'd1, COND_CS = 4'd2, COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4, COND_PL = 4'd5, COND_VS = 4'd6, COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8, COND_LS = 4'd9, COND_GE = 4'd10, COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15;
  function automatic logic [2:0] cmd_alu(input logic [3:0] cmd);
    return (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
           cmd == CMD_AND ? ALU_AND :
           cmd == CMD_ORR ? ALU_ORR :
           cmd == CMD_EOR ? ALU_EOR : ALU_ADD;
  endfunction
  function automatic logic cmd_writes(input logic [3:0] cmd);
    return cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_EOR};
  endfunction
endpackage

// File: rtl/mc_control_unit_cond_check.sv
// cond_check: combinational ARM condition evaluation; ports cond[3:0], nzcv[3:0] in, pass out (NV never passes)
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = n == v;
      COND_LT: pass = n != v;
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle ARM-subset control FSM + NZCV flag register; in clk, reset (async active-low), Instr, ALUFlags; out write enables, mux selects, ALUControl, CondFlags; CTRL_MUL_LONG_EN enables UMULL/SMULL
module mc_control_unit
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWriteHi,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic [3:0]  CondFlags
);
  state_t state;
  logic [3:0] flags;
  logic [3:0] cmd;
  logic [1:0] op;
  logic pass, mul, long_ok, hi, pcw, rw, mw, irw, hiw, unused;
  assign op = Instr[27:26];
  assign cmd = Instr[24:21];
  assign mul = Instr[27:24] == 4'd0 && Instr[7:4] == 4'b1001;
  assign unused = ^{Instr[19:8], Instr[3:0]};
  assign CondFlags = flags;
`ifdef CTRL_MUL_LONG_EN
  assign long_ok = 1'b1;
  assign hi = Instr[23];
`else
  assign long_ok = !Instr[23];
  assign hi = 1'b0;
`endif
  cond_check u_cond (.cond(Instr[31:28]), .nzcv(flags), .pass(pass));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_FETCH;
      flags <= '0;
    end else begin
      if ((state == S_EXECR || state == S_EXECI) && (Instr[20] || cmd == CMD_CMP))
        flags <= ALUFlags;
      case (state)
        S_FETCH:          state <= S_DECODE;
        S_DECODE:         state <= !pass ? S_FETCH :
                                   mul ? (long_ok ? S_MULEX : S_FETCH) :
                                   op == OP_MEM ? S_MEMADR :
                                   op == OP_BR ? S_BRANCH :
                                   op == OP_DP ? (Instr[25] ? S_EXECI : S_EXECR) : S_FETCH;
        S_MEMADR:         state <= Instr[20] ? S_MEMRD : S_MEMWR;
        S_MEMRD:          state <= S_MEMWB;
        S_EXECR, S_EXECI: state <= S_ALUWB;
        S_MULEX:          state <= S_MULWB;
        default:          state <= S_FETCH;
      endcase
    end
  always_comb begin
    {pcw, rw, mw, irw, hiw, AdrSrc, ALUSrcA} = '0;
    RegSrc = 2'b00;
    ALUSrcB = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    ImmSrc = IMM_DP;
    ALUControl = ALU_ADD;
    case (state)
      S_FETCH: begin
        irw = 1'b1;
        pcw = 1'b1;
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ResultSrc = RES_ALU;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ResultSrc = RES_ALU;
        RegSrc = {op == OP_MEM && !Instr[20], op == OP_BR};
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc = IMM_MEM;
        ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        rw = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mw = 1'b1;
      end
      S_EXECR: ALUControl = cmd_alu(cmd);
      S_EXECI: begin
        ALUSrcB = SRCB_IMM;
        ALUControl = cmd_alu(cmd);
      end
      S_ALUWB: rw = cmd_writes(cmd);
      S_BRANCH: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc = IMM_BR;
        ResultSrc = RES_ALU;
        pcw = 1'b1;
      end
      S_MULEX: ALUControl = Instr[23] ? {2'b11, Instr[22]} : ALU_MUL;
      S_MULWB: begin
        rw = 1'b1;
        hiw = hi;
      end
      default: ;
    endcase
  end
  // reset gates the enables combinationally so an aborted instruction cannot write
  assign PCWrite = reset && pcw;
  assign RegWrite = reset && rw;
  assign MemWrite = reset && mw;
  assign IRWrite = reset && irw;
  assign RegWriteHi = reset && hiw;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: directed + random instruction sequences checked cycle by cycle against a behavioural control model
module tb_mc_control_unit;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] Instr = '0;
  logic [3:0] ALUFlags = '0;
  logic PCWrite, RegWrite, MemWrite, IRWrite, RegWriteHi, AdrSrc, ALUSrcA;
  logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] CondFlags;
  logic [3:0] flags = '0;
  logic [17:0] obs;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mc_control_unit dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWriteHi(RegWriteHi), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .RegSrc(RegSrc),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .CondFlags(CondFlags)
  );
  assign obs = {PCWrite, RegWrite, MemWrite, IRWrite, RegWriteHi, AdrSrc, ALUSrcA,
                RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
  function automatic logic [17:0] v(input logic pc, rw, mw, ir, hi, adr, sa,
                                    input logic [1:0] rs, sb, res, imm, input logic [2:0] alu);
    return {pc, rw, mw, ir, hi, adr, sa, rs, sb, res, imm, alu};
  endfunction
  // ARM conditions come in complementary pairs: odd codes invert the even base test
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, ov, base;
    {n, z, cy, ov} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = ov;
      3'd4: base = cy && !z;
      3'd5: base = n == ov;
      3'd6: base = !z && (n == ov);
      default: base = 1'b1;
    endcase
    return c == 4'hF ? 1'b0 : (c[0] ? !base : base);
  endfunction
  function automatic logic [2:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 3'b001;
      4'b0000:          return 3'b010;
      4'b1100:          return 3'b011;
      4'b0001:          return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [17:0] exp, input logic [17:0] care);
    checks++;
    assert ((obs & care) === (exp & care)) else begin
      errors++;
      $error("FAIL %s ctrl observed=%h expected=%h", tag, obs & care, exp & care);
    end
    checks++;
    assert (CondFlags === flags) else begin
      errors++;
      $error("FAIL %s CondFlags observed=%b expected=%b", tag, CondFlags, flags);
    end
  endtask
  task automatic step(input string tag, input logic [17:0] exp, input logic [17:0] care, input logic [3:0] af);
    ALUFlags = af;
    @(negedge clk);
    chk(tag, exp, care);
    @(posedge clk);
    #1;
  endtask
  // one full instruction from FETCH back to the next FETCH; abort asserts reset inside MEMWR
  task automatic run_instr(input string tag, input logic [31:0] ins, input logic [3:0] exec_af, input bit abort);
    logic [1:0] op;
    logic [3:0] cmd;
    bit is_mul, lng, ld, upd;
    op = ins[27:26];
    cmd = ins[24:21];
    ld = ins[20];
    lng = ins[23];
    is_mul = ins[27:24] == 4'd0 && ins[7:4] == 4'b1001;
    Instr = ins;
    step({tag, "/fetch"}, v(1, 0, 0, 1, 0, 0, 1, 2'd0, 2'd2, 2'd2, 2'd0, 3'd0),
         v(1, 1, 1, 1, 1, 1, 1, 2'd0, 2'd3, 2'd3, 2'd0, 3'd7), 4'($urandom));
    step({tag, "/decode"}, v(0, 0, 0, 0, 0, 0, 1, {op == 2'b01 && !ld, op == 2'b10}, 2'd2, 2'd2, 2'd0, 3'd0),
         v(1, 1, 1, 1, 1, 0, 1, 2'd3, 2'd3, 2'd3, 2'd0, 3'd7), 4'($urandom));
    if (!cond_ok(ins[31:28], flags)) return;
    if (is_mul) begin
`ifndef CTRL_MUL_LONG_EN
      if (lng) return;
`endif
      step({tag, "/mulex"}, v(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, lng ? {2'b11, ins[22]} : 3'b101),
           v(1, 1, 1, 1, 1, 0, 1, 2'd0, 2'd3, 2'd0, 2'd0, 3'd7), 4'($urandom));
      step({tag, "/mulwb"}, v(0, 1, 0, 0, lng, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0),
           v(1, 1, 1, 1, 1, 0, 0, 2'd0, 2'd0, 2'd3, 2'd0, 3'd0), 4'($urandom));
      return;
    end
    case (op)
      2'b01: begin
        step({tag, "/memadr"}, v(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd1, ins[23] ? 3'd0 : 3'd1),
             v(1, 1, 1, 1, 1, 0, 1, 2'd0, 2'd3, 2'd0, 2'd3, 3'd7), 4'($urandom));
        if (ld) begin
          step({tag, "/memrd"}, v(0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0),
               v(1, 1, 1, 1, 1, 1, 0, 2'd0, 2'd0, 2'd3, 2'd0, 3'd0), 4'($urandom));
          step({tag, "/memwb"}, v(0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0, 3'd0),
               v(1, 1, 1, 1, 1, 0, 0, 2'd0, 2'd0, 2'd3, 2'd0, 3'd0), 4'($urandom));
        end else if (abort) begin
          ALUFlags = 4'($urandom);
          @(negedge clk);
          chk({tag, "/memwr"}, v(0, 0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0),
              v(1, 1, 1, 1, 1, 1, 0, 2'd0, 2'd0, 2'd3, 2'd0, 3'd0));
          #2 reset = 1'b0;
          flags = 4'd0;
          #1 chk({tag, "/abort"}, v(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd2, 2'd0, 3'd0),
                 v(1, 1, 1, 1, 1, 1, 1, 2'd0, 2'd3, 2'd3, 2'd0, 3'd7));
          @(posedge clk);
          #1 reset = 1'b1;
        end else
          step({tag, "/memwr"}, v(0, 0, 1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0),
               v(1, 1, 1, 1, 1, 1, 0, 2'd0, 2'd0, 2'd3, 2'd0, 3'd0), 4'($urandom));
      end
      2'b10: step({tag, "/branch"}, v(1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd2, 3'd0),
                  v(1, 1, 1, 1, 1, 0, 1, 2'd0, 2'd3, 2'd3, 2'd3, 3'd7), 4'($urandom));
      2'b00: begin
        upd = ins[20] || cmd == 4'b1010;
        if (ins[25])
          step({tag, "/execi"}, v(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd0, alu_of(cmd)),
               v(1, 1, 1, 1, 1, 0, 1, 2'd0, 2'd3, 2'd0, 2'd3, 3'd7), exec_af);
        else
          step({tag, "/execr"}, v(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, alu_of(cmd)),
               v(1, 1, 1, 1, 1, 0, 1, 2'd0, 2'd3, 2'd0, 2'd0, 3'd7), exec_af);
        if (upd) flags = exec_af;
        step({tag, "/aluwb"}, v(0, cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001}, 0, 0, 0, 0, 0,
             2'd0, 2'd0, 2'd0, 2'd0, 3'd0), v(1, 1, 1, 1, 1, 0, 0, 2'd0, 2'd0, 2'd3, 2'd0, 3'd0), 4'($urandom));
      end
      default: ;
    endcase
  endtask
  initial begin
    logic [31:0] r;
    repeat (3) begin
      ALUFlags = 4'($urandom);
      @(negedge clk);
      chk("reset", v(0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 2'd2, 2'd0, 3'd0),
          v(1, 1, 1, 1, 1, 1, 1, 2'd0, 2'd3, 2'd3, 2'd0, 3'd7));
      @(posedge clk);
    end
    #1 reset = 1'b1;
    run_instr("add", 32'hE0821003, 4'b1111, 1'b0);
    run_instr("cmp_z", 32'hE1510002, 4'b0100, 1'b0);
    run_instr("beq_taken", 32'h0A000002, 4'b0000, 1'b0);
    run_instr("cmp_nz", 32'hE1510002, 4'b0000, 1'b0);
    run_instr("beq_fail", 32'h0A000002, 4'b0000, 1'b0);
    run_instr("ldr", 32'hE5910004, 4'b0000, 1'b0);
    run_instr("ldr_sub", 32'hE5110004, 4'b0000, 1'b0);
    run_instr("smull", 32'hE0C54392, 4'b0000, 1'b0);
    run_instr("umull", 32'hE0854392, 4'b0000, 1'b0);
    run_instr("mul", 32'hE0050392, 4'b0000, 1'b0);
    run_instr("adds", 32'hE2921001, 4'b1010, 1'b0);
    run_instr("orr_nos", 32'hE1821003, 4'b0101, 1'b0);
    run_instr("undef_cmd", 32'hE0A21003, 4'b0000, 1'b0);
    run_instr("nv", 32'hF0821003, 4'b0000, 1'b0);
    run_instr("op11", 32'hEC000000, 4'b0000, 1'b0);
    run_instr("str", 32'hE5810004, 4'b0000, 1'b0);
    run_instr("str_abort", 32'hE5810004, 4'b0000, 1'b1);
    run_instr("after_abort", 32'hE0821003, 4'b0011, 1'b0);
    for (int k = 0; k < 80; k++) begin
      r = $urandom;
      if ($urandom_range(1) == 1) r[31:28] = 4'hE;
      if ($urandom_range(3) == 0) begin
        r[27:24] = 4'd0;
        r[7:4] = 4'b1001;
      end
      run_instr($sformatf("rnd%0d", k), r, 4'($urandom), 1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
